// File: rtl/cpu5_lsu_ctrl.sv
// cpu5 load/store sequencer.
// Takes a decoded lw/sw from EX and runs one word access on the dbus
// req/ack handshake. The pipeline is stalled while the access is in flight.
// On completion it either returns load data to writeback or raises a
// memory exception. Misaligned, bus-error and timeout cases raise exceptions.
module cpu5_lsu_ctrl #(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned CNT_W   = 8
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        ex_valid,
   input  logic        ex_memtoreg,
   input  logic        ex_memwrite,
   input  logic [31:0] ex_addr,
   input  logic [31:0] ex_wdata,
   input  logic [4:0]  ex_rd,
   output logic        stall,
   output logic        dbus_req,
   output logic        dbus_we,
   output logic [31:0] dbus_addr,
   output logic [31:0] dbus_wdata,
   input  logic        dbus_ack,
   input  logic        dbus_err,
   input  logic [31:0] dbus_rdata,
   output logic        wb_valid,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        excp_valid,
   output logic [1:0]  excp_cause,
   output logic [31:0] excp_addr
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   localparam logic [1:0] CAUSE_LD_MISALIGN = 2'b01;
   localparam logic [1:0] CAUSE_ST_MISALIGN = 2'b10;
   localparam logic [1:0] CAUSE_BUS         = 2'b11;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   // Counter value seen in the last BUSY cycle allowed before the abort.
   // Only meaningful when TIMEOUT is non-zero.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   logic [0:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             we_q, we_d;
   logic [31:0]      addr_q, addr_d;
   logic [31:0]      wdata_q, wdata_d;
   logic [4:0]       rd_q, rd_d;
   logic             load_q, load_d;
   logic             wb_valid_q, wb_valid_d;
   logic [4:0]       wb_rd_q, wb_rd_d;
   logic [31:0]      wb_data_q, wb_data_d;
   logic             excp_valid_q, excp_valid_d;
   logic [1:0]       excp_cause_q, excp_cause_d;
   logic [31:0]      excp_addr_q, excp_addr_d;

   logic             accept;
   logic             timeout_hit;

   assign accept      = ex_valid & (ex_memtoreg | ex_memwrite);
   assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

   // Next-state logic: accept in IDLE, completion/timeout in BUSY.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      rd_d         = rd_q;
      load_d       = load_q;
      wb_valid_d   = 1'b0;
      wb_rd_d      = wb_rd_q;
      wb_data_d    = wb_data_q;
      excp_valid_d = 1'b0;
      excp_cause_d = excp_cause_q;
      excp_addr_d  = excp_addr_q;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (ex_addr[1:0] != 2'b00) begin
                  // Misaligned: report immediately, never touch the bus.
                  excp_valid_d = 1'b1;
                  excp_cause_d = ex_memtoreg ? CAUSE_LD_MISALIGN : CAUSE_ST_MISALIGN;
                  excp_addr_d  = ex_addr;
               end else begin
                  // A load wins when both controls are set.
                  state_d = ST_BUSY;
                  cnt_d   = '0;
                  we_d    = ex_memwrite & ~ex_memtoreg;
                  addr_d  = {ex_addr[31:2], 2'b00};
                  wdata_d = ex_wdata;
                  rd_d    = ex_rd;
                  load_d  = ex_memtoreg;
               end
            end
         end
         default: begin
            if (dbus_ack) begin
               // Ack has priority over a timeout firing in the same cycle.
               state_d = ST_IDLE;
               we_d    = 1'b0;
               if (dbus_err) begin
                  excp_valid_d = 1'b1;
                  excp_cause_d = CAUSE_BUS;
                  excp_addr_d  = addr_q;
               end else if (load_q && (rd_q != 5'd0)) begin
                  wb_valid_d = 1'b1;
                  wb_rd_d    = rd_q;
                  wb_data_d  = dbus_rdata;
               end
            end else if (timeout_hit) begin
               state_d      = ST_IDLE;
               we_d         = 1'b0;
               excp_valid_d = 1'b1;
               excp_cause_d = CAUSE_BUS;
               excp_addr_d  = addr_q;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
      endcase
   end

   // State and output registers; reset drops the request immediately.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         rd_q         <= '0;
         load_q       <= 1'b0;
         wb_valid_q   <= 1'b0;
         wb_rd_q      <= '0;
         wb_data_q    <= '0;
         excp_valid_q <= 1'b0;
         excp_cause_q <= '0;
         excp_addr_q  <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         rd_q         <= rd_d;
         load_q       <= load_d;
         wb_valid_q   <= wb_valid_d;
         wb_rd_q      <= wb_rd_d;
         wb_data_q    <= wb_data_d;
         excp_valid_q <= excp_valid_d;
         excp_cause_q <= excp_cause_d;
         excp_addr_q  <= excp_addr_d;
      end
   end

   // Stall and request are exactly the BUSY state flop.
   assign stall      = (state_q == ST_BUSY);
   assign dbus_req   = (state_q == ST_BUSY);
   assign dbus_we    = we_q;
   assign dbus_addr  = addr_q;
   assign dbus_wdata = wdata_q;
   assign wb_valid   = wb_valid_q;
   assign wb_rd      = wb_rd_q;
   assign wb_data    = wb_data_q;
   assign excp_valid = excp_valid_q;
   assign excp_cause = excp_cause_q;
   assign excp_addr  = excp_addr_q;

endmodule

// File: tb/tb_cpu5_lsu_ctrl.sv
// Bench for cpu5_lsu_ctrl: directed vector table, reset corner case,
// then random traffic against a transaction-level reference model.
module tb_cpu5_lsu_ctrl;

   localparam int TO = 4;
   localparam int NV = 27;
   localparam int NRAND = 3000;

   logic        clk = 1'b0;
   logic        resetn;
   logic        ex_valid, ex_memtoreg, ex_memwrite;
   logic [31:0] ex_addr, ex_wdata;
   logic [4:0]  ex_rd;
   logic        stall, dbus_req, dbus_we;
   logic [31:0] dbus_addr, dbus_wdata;
   logic        dbus_ack, dbus_err;
   logic [31:0] dbus_rdata;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        excp_valid;
   logic [1:0]  excp_cause;
   logic [31:0] excp_addr;

   cpu5_lsu_ctrl #(.TIMEOUT(TO), .CNT_W(3)) dut (
      .clk(clk), .resetn(resetn),
      .ex_valid(ex_valid), .ex_memtoreg(ex_memtoreg), .ex_memwrite(ex_memwrite),
      .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
      .stall(stall), .dbus_req(dbus_req), .dbus_we(dbus_we),
      .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata),
      .dbus_ack(dbus_ack), .dbus_err(dbus_err), .dbus_rdata(dbus_rdata),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
      .excp_valid(excp_valid), .excp_cause(excp_cause), .excp_addr(excp_addr)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Inputs, then outputs expected right after the following clock edge.
   typedef struct {
      int v, ml, mw; logic [31:0] addr, wdata; int rd, ack, err; logic [31:0] rdata;
      int stall, req, we; logic [31:0] daddr, dwd;
      int wbv, wbrd; logic [31:0] wbd;
      int exv, cause; logic [31:0] ea;
   } vec_t;

   vec_t tbl [0:NV-1];

   task automatic chk(input string name, input int tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s @%0d: got %h want %h", name, tag, act, exp);
      end
   endtask

   task automatic drive(input int v, input int ml, input int mw, input logic [31:0] a,
                        input logic [31:0] wd, input int rd, input int ack, input int err,
                        input logic [31:0] rdat);
      ex_valid    = 1'(v);
      ex_memtoreg = 1'(ml);
      ex_memwrite = 1'(mw);
      ex_addr     = a;
      ex_wdata    = wd;
      ex_rd       = 5'(rd);
      dbus_ack    = 1'(ack);
      dbus_err    = 1'(err);
      dbus_rdata  = rdat;
   endtask

   // ---------------- reference model (transaction level) ----------------
   bit          m_pend;
   logic [31:0] m_addr, m_wdata;
   logic [4:0]  m_rd;
   bit          m_load;
   int          m_wait;      // BUSY cycles that passed with no ack
   bit          e_wbv, e_exv;
   logic [4:0]  e_wbrd;
   logic [31:0] e_wbd, e_ea;
   logic [1:0]  e_cause;

   task automatic model_reset();
      m_pend = 0; m_addr = '0; m_wdata = '0; m_rd = '0; m_load = 0; m_wait = 0;
      e_wbv = 0; e_exv = 0; e_wbrd = '0; e_wbd = '0; e_ea = '0; e_cause = '0;
   endtask

   // Predict the outputs after the next edge from the inputs now driven.
   task automatic model_step();
      e_wbv = 0;
      e_exv = 0;
      if (!m_pend) begin
         if (ex_valid && (ex_memtoreg || ex_memwrite)) begin
            if (ex_addr % 4 != 0) begin
               e_exv = 1; e_cause = ex_memtoreg ? 2'd1 : 2'd2; e_ea = ex_addr;
            end else begin
               m_pend = 1; m_addr = ex_addr; m_wdata = ex_wdata;
               m_rd = ex_rd; m_load = ex_memtoreg; m_wait = 0;
            end
         end
      end else if (dbus_ack) begin
         m_pend = 0;
         if (dbus_err) begin
            e_exv = 1; e_cause = 2'd3; e_ea = m_addr;
         end else if (m_load && m_rd != 0) begin
            e_wbv = 1; e_wbrd = m_rd; e_wbd = dbus_rdata;
         end
      end else begin
         m_wait++;
         if (TO != 0 && m_wait == TO) begin
            m_pend = 0; e_exv = 1; e_cause = 2'd3; e_ea = m_addr;
         end
      end
   endtask

   task automatic check_model(input int tag);
      chk("r_stall", tag, 32'(stall), 32'(m_pend));
      chk("r_req", tag, 32'(dbus_req), 32'(m_pend));
      if (m_pend) begin
         chk("r_we", tag, 32'(dbus_we), 32'(!m_load));
         chk("r_addr", tag, dbus_addr, m_addr);
         chk("r_wdata", tag, dbus_wdata, m_wdata);
      end
      chk("r_wbv", tag, 32'(wb_valid), 32'(e_wbv));
      chk("r_wbrd", tag, 32'(wb_rd), 32'(e_wbrd));
      chk("r_wbd", tag, wb_data, e_wbd);
      chk("r_exv", tag, 32'(excp_valid), 32'(e_exv));
      chk("r_cause", tag, 32'(excp_cause), 32'(e_cause));
      chk("r_ea", tag, excp_addr, e_ea);
   endtask

   initial begin
      logic [31:0] a;
      int n_acc;
      // v ml mw addr wdata rd ack err rdata | stall req we daddr dwd | wbv wbrd wbd | exv cause ea
      tbl[0]  = '{1,1,0,32'h100,0,5,0,0,0,           1,1,0,32'h100,0,          0,0,0,                 0,0,0};
      tbl[1]  = '{0,0,0,0,0,0,0,0,0,                 1,1,0,32'h100,0,          0,0,0,                 0,0,0};
      tbl[2]  = '{0,0,0,0,0,0,0,0,0,                 1,1,0,32'h100,0,          0,0,0,                 0,0,0};
      tbl[3]  = '{0,0,0,0,0,0,0,0,0,                 1,1,0,32'h100,0,          0,0,0,                 0,0,0};
      tbl[4]  = '{0,0,0,0,0,0,1,0,32'hDEADBEEF,      0,0,0,0,0,                1,5,32'hDEADBEEF,      0,0,0};
      tbl[5]  = '{1,0,1,32'h204,32'h12345678,0,0,0,0, 1,1,1,32'h204,32'h12345678, 0,5,32'hDEADBEEF,   0,0,0};
      tbl[6]  = '{0,0,0,0,0,0,1,0,0,                 0,0,0,0,0,                0,5,32'hDEADBEEF,      0,0,0};
      tbl[7]  = '{1,1,0,32'h102,0,3,0,0,0,           0,0,0,0,0,                0,5,32'hDEADBEEF,      1,1,32'h102};
      tbl[8]  = '{1,0,1,32'h3,0,0,0,0,0,             0,0,0,0,0,                0,5,32'hDEADBEEF,      1,2,32'h3};
      tbl[9]  = '{0,0,0,0,0,0,0,0,0,                 0,0,0,0,0,                0,5,32'hDEADBEEF,      0,2,32'h3};
      tbl[10] = '{1,1,0,32'h300,0,7,0,0,0,           1,1,0,32'h300,0,          0,5,32'hDEADBEEF,      0,2,32'h3};
      tbl[11] = '{0,0,0,0,0,0,1,1,32'h55,            0,0,0,0,0,                0,5,32'hDEADBEEF,      1,3,32'h300};
      tbl[12] = '{1,0,1,32'h400,32'hAA,0,0,0,0,      1,1,1,32'h400,32'hAA,     0,5,32'hDEADBEEF,      0,3,32'h300};
      tbl[13] = '{0,0,0,0,0,0,0,0,0,                 1,1,1,32'h400,32'hAA,     0,5,32'hDEADBEEF,      0,3,32'h300};
      tbl[14] = '{0,0,0,0,0,0,0,0,0,                 1,1,1,32'h400,32'hAA,     0,5,32'hDEADBEEF,      0,3,32'h300};
      tbl[15] = '{0,0,0,0,0,0,0,0,0,                 1,1,1,32'h400,32'hAA,     0,5,32'hDEADBEEF,      0,3,32'h300};
      tbl[16] = '{0,0,0,0,0,0,0,0,0,                 0,0,0,0,0,                0,5,32'hDEADBEEF,      1,3,32'h400};
      tbl[17] = '{1,1,0,32'h500,0,0,0,0,0,           1,1,0,32'h500,0,          0,5,32'hDEADBEEF,      0,3,32'h400};
      tbl[18] = '{0,0,0,0,0,0,1,0,32'h99,            0,0,0,0,0,                0,5,32'hDEADBEEF,      0,3,32'h400};
      tbl[19] = '{1,1,1,32'h600,32'h77,9,0,0,0,      1,1,0,32'h600,32'h77,     0,5,32'hDEADBEEF,      0,3,32'h400};
      tbl[20] = '{1,0,1,32'h800,1,0,1,0,32'h600D,    0,0,0,0,0,                1,9,32'h600D,          0,3,32'h400};
      tbl[21] = '{1,1,0,32'h700,0,4,0,0,0,           1,1,0,32'h700,0,          0,9,32'h600D,          0,3,32'h400};
      tbl[22] = '{1,0,1,32'h704,32'hCAFE,0,1,0,32'h1111, 0,0,0,0,0,            1,4,32'h1111,          0,3,32'h400};
      tbl[23] = '{1,0,1,32'h704,32'hCAFE,0,0,0,0,    1,1,1,32'h704,32'hCAFE,   0,4,32'h1111,          0,3,32'h400};
      tbl[24] = '{0,0,0,0,0,0,1,0,0,                 0,0,0,0,0,                0,4,32'h1111,          0,3,32'h400};
      tbl[25] = '{0,0,0,0,0,0,1,1,32'hFFFF,          0,0,0,0,0,                0,4,32'h1111,          0,3,32'h400};
      tbl[26] = '{1,0,0,32'h900,0,0,0,0,0,           0,0,0,0,0,                0,4,32'h1111,          0,3,32'h400};

      // ---------------- reset state ----------------
      resetn = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_stall", 0, 32'(stall), 0);
      chk("rst_req", 0, 32'(dbus_req), 0);
      chk("rst_we", 0, 32'(dbus_we), 0);
      chk("rst_addr", 0, dbus_addr, 0);
      chk("rst_wdata", 0, dbus_wdata, 0);
      chk("rst_wbv", 0, 32'(wb_valid), 0);
      chk("rst_wbrd", 0, 32'(wb_rd), 0);
      chk("rst_wbd", 0, wb_data, 0);
      chk("rst_exv", 0, 32'(excp_valid), 0);
      chk("rst_cause", 0, 32'(excp_cause), 0);
      chk("rst_ea", 0, excp_addr, 0);
      resetn = 1'b1;

      // ---------------- directed table ----------------
      for (int i = 0; i < NV; i++) begin
         drive(tbl[i].v, tbl[i].ml, tbl[i].mw, tbl[i].addr, tbl[i].wdata,
               tbl[i].rd, tbl[i].ack, tbl[i].err, tbl[i].rdata);
         @(posedge clk);
         #1;
         chk("t_stall", i, 32'(stall), 32'(tbl[i].stall));
         chk("t_req", i, 32'(dbus_req), 32'(tbl[i].req));
         if (tbl[i].req != 0) begin
            chk("t_we", i, 32'(dbus_we), 32'(tbl[i].we));
            chk("t_addr", i, dbus_addr, tbl[i].daddr);
            chk("t_wdata", i, dbus_wdata, tbl[i].dwd);
         end
         chk("t_wbv", i, 32'(wb_valid), 32'(tbl[i].wbv));
         chk("t_wbrd", i, 32'(wb_rd), 32'(tbl[i].wbrd));
         chk("t_wbd", i, wb_data, tbl[i].wbd);
         chk("t_exv", i, 32'(excp_valid), 32'(tbl[i].exv));
         chk("t_cause", i, 32'(excp_cause), 32'(tbl[i].cause));
         chk("t_ea", i, excp_addr, tbl[i].ea);
         $display("vec %0d addr=%h done, bad so far=%0d", i, tbl[i].addr, bad);
      end

      // ---------------- reset in the middle of an access ----------------
      drive(1, 1, 0, 32'h1000, 0, 6, 0, 0, 0);
      @(posedge clk);
      #1;
      chk("mid_req_up", 0, 32'(dbus_req), 1);
      drive(0, 0, 0, 0, 0, 0, 1, 0, 32'h4242);
      #2 resetn = 1'b0;
      #1;
      chk("mid_req_drop", 0, 32'(dbus_req), 0);
      chk("mid_stall_drop", 0, 32'(stall), 0);
      @(posedge clk);
      #1 resetn = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         chk("post_rst_wbv", k, 32'(wb_valid), 0);
         chk("post_rst_exv", k, 32'(excp_valid), 0);
         chk("post_rst_req", k, 32'(dbus_req), 0);
      end
      $display("reset-mid-access sequence done, bad so far=%0d", bad);

      // ---------------- random traffic vs model ----------------
      model_reset();
      n_acc = 0;
      for (int c = 0; c < NRAND; c++) begin
         a = $urandom();
         if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
         drive(($urandom_range(0, 3) != 0) ? 1 : 0, int'($urandom_range(0, 1)),
               int'($urandom_range(0, 1)), a, $urandom(), int'($urandom_range(0, 31)),
               ($urandom_range(0, 2) == 0) ? 1 : 0, ($urandom_range(0, 7) == 0) ? 1 : 0,
               $urandom());
         model_step();
         if (e_wbv || e_exv) n_acc++;
         @(posedge clk);
         #1;
         check_model(c);
      end
      $display("random phase: %0d cycles, %0d wb/excp pulses predicted, bad so far=%0d", NRAND, n_acc, bad);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cpu5_lsu_ctrl.md
Name: cpu5_lsu_ctrl

Overview:
Load/store sequencer for the cpu5 core. It takes the memtoreg/memwrite controls from the main decoder and the ALU-computed address, then runs one word access on the data-bus request/acknowledge handshake. While the access is outstanding it stalls the pipeline. At the end it returns load data to writeback, or raises a memory exception.

Parameters:
TIMEOUT, 255, maximum BUSY cycles without dbus_ack before abort; 0 disables the timeout.
CNT_W, 8, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
clk  in  1  core clock.
resetn  in  1  asynchronous active-low reset.
ex_valid  in  1  EX stage holds a valid instruction.
ex_memtoreg  in  1  decoder load control (lw).
ex_memwrite  in  1  decoder store control (sw).
ex_addr  in  32  effective address from ALU (rs1+imm).
ex_wdata  in  32  store data (rs2).
ex_rd  in  5  load destination register.
stall  out  1  freeze upstream stages; ex_* ignored while high.
dbus_req  out  1  bus request.
dbus_we  out  1  1 = write.
dbus_addr  out  32  word address, bits [1:0] always 0.
dbus_wdata  out  32  write data.
dbus_ack  in  1  access complete; valid only while dbus_req is high.
dbus_err  in  1  bus error, qualified by dbus_ack.
dbus_rdata  in  32  read data, qualified by dbus_ack.
wb_valid  out  1  one-cycle pulse: load data ready.
wb_rd  out  5  load destination register.
wb_data  out  32  load data.
excp_valid  out  1  one-cycle exception pulse.
excp_cause  out  2  01 load misaligned; 10 store misaligned; 11 bus error or timeout.
excp_addr  out  32  faulting address.

Behaviour:
- Reset (asynchronous, resetn=0):
  - state=IDLE, counter=0.
  - All outputs are 0, including stall and dbus_req.
  - Reset mid-access drops dbus_req immediately; no wb or excp pulse is produced for the aborted access.
- States: IDLE, BUSY. All outputs are registered.
- Accept: in IDLE with ex_valid & (ex_memtoreg | ex_memwrite).
  - If both controls are set, the access is treated as a load.
  - ex_valid with neither control set: no action.
- Aligned accept (ex_addr[1:0]==0):
  - Next cycle: state=BUSY, stall=1, dbus_req=1.
  - dbus_we=ex_memwrite & ~ex_memtoreg.
  - dbus_addr, dbus_wdata and the rd/type bits are latched; they hold stable until the completion cycle.
  - Counter cleared.
- Misaligned accept (ex_addr[1:0]!=0):
  - No bus request; state stays IDLE and stall stays 0.
  - Next cycle: excp_valid=1, cause 01 or 10, excp_addr=ex_addr.
- BUSY, completion (dbus_ack=1 in a cycle):
  - Next cycle: state=IDLE, stall=0, dbus_req=0. Minimum access latency is 2 cycles from accept to wb_valid.
  - If dbus_err=1: excp_valid=1, cause=11, excp_addr=latched address; wb_valid=0.
  - If dbus_err=0 and the access is a load with rd!=0: wb_valid=1, wb_rd=latched rd, wb_data=dbus_rdata (sampled in the ack cycle).
  - Loads to rd==0 and all stores produce no wb_valid.
- BUSY, no ack:
  - Counter increments and saturates.
  - If TIMEOUT!=0 and counter==TIMEOUT-1 without ack: next cycle return to IDLE, dbus_req=0, excp_valid=1, cause=11.
  - If ack arrives in the same cycle the timeout would fire, ack wins.
- No back-to-back issue: the first accept is possible in the cycle stall falls. The ex_* inputs are sampled in that cycle.
- dbus_ack while IDLE is ignored.
- wb_valid and excp_valid are never high in the same cycle.
- wb_data, wb_rd and excp_addr hold their last values between pulses.

Test Plan:
- Load, aligned: lw addr 0x100, rd=5, ack 3 cycles after req with rdata 0xDEADBEEF → stall high for 4 cycles; wb_valid pulse with rd=5, data=0xDEADBEEF; dbus_we=0.
- Store, zero-wait: sw addr 0x204, wdata 0x12345678, ack in first BUSY cycle → one stall cycle, dbus_we=1, addr 0x204; no wb_valid, no excp.
- Misaligned: lw addr 0x102 → no dbus_req; excp_valid next cycle, cause 01, excp_addr 0x102. sw addr 0x3 → cause 10.
- Bus error and timeout: ack with err=1 → cause 11, no wb_valid. With TIMEOUT=4 and no ack → req drops after 4 BUSY cycles, excp cause 11. Ack on the 4th cycle → normal completion.
- Edge cases: lw rd=0 → no wb_valid. Both controls set → read access. Back-to-back lw/sw → second accept in the cycle stall falls.
- Reset and ignored ack: resetn pulled low mid-BUSY → dbus_req and stall 0 immediately, no pulses after release. Stray ack in IDLE → no effect.
